// File: rtl/hub75_pkg.sv
// Shared types and default geometry for the HUB75 double-buffered frame buffer.
package hub75_pkg;

    localparam int HPIXEL_D = 64;
    localparam int VPIXEL_D = 64;
    localparam int BPP_D    = 8;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } fb_state_e;

    typedef struct packed {
        logic [BPP_D-1:0] r;
        logic [BPP_D-1:0] g;
        logic [BPP_D-1:0] b;
    } pixel_t;

endpackage

// File: rtl/hub75_dblbuf_framebuf_if.sv
// Write, read, swap and clear signals between pixel source / scan controller and the frame buffer.
interface hub75_dblbuf_framebuf_if #(
    parameter int HPIXEL_P = hub75_pkg::HPIXEL_D,
    parameter int VPIXEL_P = hub75_pkg::VPIXEL_D,
    parameter int BPP_P    = hub75_pkg::BPP_D
);
    localparam int FRAME_SIZE_P = HPIXEL_P * VPIXEL_P;
    localparam int HALF_SIZE_P  = FRAME_SIZE_P / 2;
    localparam int ADDR_W_P     = $clog2(FRAME_SIZE_P);
    localparam int RADDR_W_P    = $clog2(HALF_SIZE_P);

    logic [ADDR_W_P-1:0]        i_wr_addr;
    logic [3*BPP_P-1:0]         i_wr_data;
    logic                       i_wr_en;
    logic                       o_wr_ready;
    logic [RADDR_W_P-1:0]       i_rd_addr;
    logic                       i_rd_en;
    logic [2:0][BPP_P-1:0]      o_rd_top;
    logic [2:0][BPP_P-1:0]      o_rd_bot;
    logic                       o_rd_valid;
    logic                       i_swap_req;
    logic                       i_frame_end;
    logic                       o_swap_done;
    logic                       o_front_sel;
    logic                       i_clear;
    logic                       o_busy;

    modport master (
        output i_wr_addr, i_wr_data, i_wr_en, i_rd_addr, i_rd_en,
               i_swap_req, i_frame_end, i_clear,
        input  o_wr_ready, o_rd_top, o_rd_bot, o_rd_valid,
               o_swap_done, o_front_sel, o_busy
    );

    modport slave (
        input  i_wr_addr, i_wr_data, i_wr_en, i_rd_addr, i_rd_en,
               i_swap_req, i_frame_end, i_clear,
        output o_wr_ready, o_rd_top, o_rd_bot, o_rd_valid,
               o_swap_done, o_front_sel, o_busy
    );

endinterface

// File: rtl/hub75_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, no reset on contents.
module hub75_dp_ram #(
    parameter int DEPTH_P = 2048,
    parameter int WIDTH_P = 24,
    localparam int AW_P   = $clog2(DEPTH_P)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [AW_P-1:0]    waddr,
    input  logic [WIDTH_P-1:0] wdata,
    input  logic               re,
    input  logic [AW_P-1:0]    raddr,
    output logic [WIDTH_P-1:0] rdata
);

    logic [WIDTH_P-1:0] mem [DEPTH_P];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/hub75_dblbuf_framebuf.sv
// Double-buffered HUB75 frame buffer: back bank written/cleared, front bank read as row pairs,
// swap committed only at a frame boundary.
module hub75_dblbuf_framebuf
    import hub75_pkg::*;
#(
    parameter int HPIXEL_P = HPIXEL_D,
    parameter int VPIXEL_P = VPIXEL_D,
    parameter int BPP_P    = BPP_D
) (
    input  logic                     clk,
    input  logic                     rst,
    hub75_dblbuf_framebuf_if.slave   bus
);

    localparam int FRAME_SIZE_P = HPIXEL_P * VPIXEL_P;
    localparam int HALF_SIZE_P  = FRAME_SIZE_P / 2;
    localparam int ADDR_W_P     = $clog2(FRAME_SIZE_P);
    localparam int RADDR_W_P    = $clog2(HALF_SIZE_P);
    localparam int PIX_W_P      = 3 * BPP_P;
    localparam int HALF_LAST_P  = HALF_SIZE_P - 1;

    localparam logic [ADDR_W_P:0]    FRAME_LIM = FRAME_SIZE_P[ADDR_W_P:0];
    localparam logic [ADDR_W_P-1:0]  HALF_A    = HALF_SIZE_P[ADDR_W_P-1:0];
    localparam logic [RADDR_W_P-1:0] LAST_OFF  = HALF_LAST_P[RADDR_W_P-1:0];

    fb_state_e            state_q, state_d;
    logic [RADDR_W_P-1:0] clr_cnt_q, clr_cnt_d;
    logic                 front_q, pending_q, swap_done_q, commit;
    logic                 rd_valid_q, rd_seen_q, rd_bank_q;
    logic                 clearing, wr_hit, wr_bot, wr_in_range;
    logic [RADDR_W_P-1:0] wr_off;
    logic [PIX_W_P-1:0]   ram_q [2][2];

    assign clearing    = (state_q == ST_CLEAR);
    assign wr_in_range = ({1'b0, bus.i_wr_addr} < FRAME_LIM);
    assign wr_bot      = (bus.i_wr_addr >= HALF_A);
    assign wr_off      = wr_bot ? RADDR_W_P'(bus.i_wr_addr - HALF_A) : RADDR_W_P'(bus.i_wr_addr);
    assign wr_hit      = bus.i_wr_en && (state_q == ST_IDLE) && wr_in_range;

    // Four RAMs indexed [bank][half]; the clear sweeps both halves of the back bank at once.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        for (genvar h = 0; h < 2; h++) begin : g_half
            logic is_back;
            logic we_w;
            assign is_back = (front_q != 1'(b));
            assign we_w    = is_back && (clearing || (wr_hit && (wr_bot == 1'(h))));

            hub75_dp_ram #(
                .DEPTH_P (HALF_SIZE_P),
                .WIDTH_P (PIX_W_P)
            ) u_ram (
                .clk   (clk),
                .we    (we_w),
                .waddr (clearing ? clr_cnt_q : wr_off),
                .wdata (clearing ? '0 : bus.i_wr_data),
                .re    (bus.i_rd_en && (front_q == 1'(b))),
                .raddr (bus.i_rd_addr),
                .rdata (ram_q[b][h])
            );
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_clear) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_OFF) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A request arriving in the commit cycle is absorbed by that same commit.
    assign commit = (pending_q || bus.i_swap_req) && bus.i_frame_end && (state_q == ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front_q     <= 1'b0;
            pending_q   <= 1'b0;
            swap_done_q <= 1'b0;
        end else begin
            front_q     <= front_q ^ commit;
            pending_q   <= !commit && (pending_q || bus.i_swap_req);
            swap_done_q <= commit;
        end
    end

    // The RAM read registers carry no reset, so outputs are gated until the first read lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_seen_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
        end else begin
            rd_valid_q <= bus.i_rd_en;
            if (bus.i_rd_en) begin
                rd_seen_q <= 1'b1;
                rd_bank_q <= front_q;
            end
        end
    end

    assign bus.o_rd_top    = rd_seen_q ? ram_q[rd_bank_q][0] : '0;
    assign bus.o_rd_bot    = rd_seen_q ? ram_q[rd_bank_q][1] : '0;
    assign bus.o_rd_valid  = rd_valid_q;
    assign bus.o_wr_ready  = (state_q == ST_IDLE);
    assign bus.o_busy      = clearing;
    assign bus.o_front_sel = front_q;
    assign bus.o_swap_done = swap_done_q;

endmodule

// File: tb/tb_hub75_dblbuf_framebuf.sv
// Scoreboard bench for hub75_dblbuf_framebuf: directed writes/swaps/clears, reads checked by a monitor.
module tb_hub75_dblbuf_framebuf;
    import hub75_pkg::*;

    localparam int HP   = 64;
    localparam int VP   = 64;
    localparam int BPP  = 8;
    localparam int HALF = HP * VP / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    logic [47:0] exp_q[$];
    logic [47:0] mon_exp;

    always #5 clk = ~clk;

    hub75_dblbuf_framebuf_if #(.HPIXEL_P(HP), .VPIXEL_P(VP), .BPP_P(BPP)) bus ();

    hub75_dblbuf_framebuf #(.HPIXEL_P(HP), .VPIXEL_P(VP), .BPP_P(BPP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check_output(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every valid read beat is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.o_rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL rd_unexpected: got a valid read beat expected none");
            end else begin
                mon_exp = exp_q.pop_front();
                check_output("rd_data", {bus.o_rd_top, bus.o_rd_bot}, mon_exp);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got no end of test expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_write(input logic [11:0] a, input logic [23:0] d);
        bus.i_wr_addr = a;
        bus.i_wr_data = d;
        bus.i_wr_en   = 1'b1;
        step();
        bus.i_wr_en   = 1'b0;
    endtask

    task automatic apply_read(input logic [10:0] a, input logic [23:0] top, input logic [23:0] bot);
        bus.i_rd_addr = a;
        bus.i_rd_en   = 1'b1;
        exp_q.push_back({top, bot});
        step();
        bus.i_rd_en   = 1'b0;
    endtask

    task automatic apply_commit(input logic exp_front);
        bus.i_swap_req  = 1'b1;
        bus.i_frame_end = 1'b1;
        step();
        bus.i_swap_req  = 1'b0;
        bus.i_frame_end = 1'b0;
        @(negedge clk);
        check_output("commit_front", 48'(bus.o_front_sel), 48'(exp_front));
        check_output("commit_done", 48'(bus.o_swap_done), 48'd1);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_front", 48'(bus.o_front_sel), 48'd0);
        check_output("rst_rd_valid", 48'(bus.o_rd_valid), 48'd0);
        check_output("rst_rd_data", {bus.o_rd_top, bus.o_rd_bot}, 48'd0);
        check_output("rst_swap_done", 48'(bus.o_swap_done), 48'd0);
        check_output("rst_busy", 48'(bus.o_busy), 48'd0);
        check_output("rst_wr_ready", 48'(bus.o_wr_ready), 48'd1);
    endtask

    // Issues i_clear and counts busy cycles; optional swap request, frame end, commit and reset events.
    task automatic apply_stimulus_clear(input int swap_at, input int fe_at, input int rst_at,
                                        input bit fe_with_clear, input logic front_during,
                                        input logic [47:0] rst_rd_exp);
        int cnt;
        cnt = 0;
        bus.i_clear = 1'b1;
        if (fe_with_clear) bus.i_frame_end = 1'b1;
        step();
        bus.i_clear     = 1'b0;
        bus.i_frame_end = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!bus.o_busy) break;
            cnt++;
            if (fe_with_clear && i == 0) begin
                check_output("clear_commit_front", 48'(bus.o_front_sel), 48'(front_during));
                check_output("clear_commit_done", 48'(bus.o_swap_done), 48'd1);
            end
            if (i == 10) begin
                check_output("wr_ready_in_clear", 48'(bus.o_wr_ready), 48'd0);
                bus.i_wr_addr = 12'd5;
                bus.i_wr_data = 24'hABCDEF;
                bus.i_wr_en   = 1'b1;
            end
            if (i == 11) bus.i_wr_en = 1'b0;
            if (swap_at >= 0 && i == swap_at) bus.i_swap_req = 1'b1;
            if (swap_at >= 0 && i == swap_at + 1) bus.i_swap_req = 1'b0;
            if (fe_at >= 0 && i == fe_at) bus.i_frame_end = 1'b1;
            if (fe_at >= 0 && i == fe_at + 1) bus.i_frame_end = 1'b0;
            if (fe_at >= 0 && i == fe_at + 2)
                check_output("no_commit_in_clear", 48'(bus.o_front_sel), 48'(front_during));
            if (rst_at >= 0 && i == rst_at - 1) begin
                bus.i_rd_addr = 11'd3;
                bus.i_rd_en   = 1'b1;
                exp_q.push_back(rst_rd_exp);
            end
            if (rst_at >= 0 && i == rst_at) begin
                bus.i_rd_en = 1'b0;
                #2 rst = 1'b1;
                #1 check_reset_outputs();
                return;
            end
        end
        check_output("clear_len", 48'(cnt), 48'(HALF));
        check_output("wr_ready_after_clear", 48'(bus.o_wr_ready), 48'd1);
    endtask

    initial begin
        bus.i_wr_addr = '0; bus.i_wr_data = '0; bus.i_wr_en = 1'b0;
        bus.i_rd_addr = '0; bus.i_rd_en = 1'b0;
        bus.i_swap_req = 1'b0; bus.i_frame_end = 1'b0; bus.i_clear = 1'b0;

        repeat (3) step();
        @(negedge clk);
        check_reset_outputs();
        step();
        rst = 1'b0;
        step();

        // Bank 1 cleared (write attempt dropped), then swap to it.
        apply_stimulus_clear(-1, -1, -1, 1'b0, 1'b0, 48'd0);
        apply_commit(1'b1);
        apply_read(11'd5, 24'h000000, 24'h000000);
        @(negedge clk);
        check_output("swap_done_pulse_end", 48'(bus.o_swap_done), 48'd0);
        apply_read(11'd0, 24'h000000, 24'h000000);

        // Bank 0 cleared, then loaded with corner pixels while bank 1 stays in front.
        apply_stimulus_clear(-1, -1, -1, 1'b0, 1'b1, 48'd0);
        apply_write(12'd0,    24'hFF0000);
        apply_write(12'd2048, 24'h00FF00);
        apply_write(12'd2047, 24'h0000FF);
        apply_write(12'd4095, 24'hFFFFFF);
        apply_read(11'd0, 24'h000000, 24'h000000);
        @(negedge clk);
        check_output("front_no_swap", 48'(bus.o_front_sel), 48'd1);

        // Pending request across three frames without frame end, plus redundant pulses.
        bus.i_swap_req = 1'b1;
        step();
        bus.i_swap_req = 1'b0;
        for (int f = 0; f < 3; f++) begin
            repeat (20) step();
            check_output("front_pending", 48'(bus.o_front_sel), 48'd1);
            bus.i_swap_req = 1'b1;
            step();
            bus.i_swap_req = 1'b0;
        end

        // Commit cycle carries a read (old front) and a write (old back).
        bus.i_frame_end = 1'b1;
        bus.i_rd_addr = 11'd0;
        bus.i_rd_en = 1'b1;
        exp_q.push_back(48'd0);
        bus.i_wr_addr = 12'd1;
        bus.i_wr_data = 24'h123456;
        bus.i_wr_en = 1'b1;
        step();
        bus.i_frame_end = 1'b0;
        bus.i_rd_en = 1'b0;
        bus.i_wr_en = 1'b0;
        @(negedge clk);
        check_output("single_toggle_front", 48'(bus.o_front_sel), 48'd0);
        check_output("single_toggle_done", 48'(bus.o_swap_done), 48'd1);
        apply_read(11'd0, 24'hFF0000, 24'h00FF00);
        @(negedge clk);
        check_output("swap_done_one_cycle", 48'(bus.o_swap_done), 48'd0);
        apply_read(11'd2047, 24'h0000FF, 24'hFFFFFF);
        apply_read(11'd1, 24'h123456, 24'h000000);
        repeat (3) step();
        @(negedge clk);
        check_output("rd_hold", {bus.o_rd_top, bus.o_rd_bot}, {24'h123456, 24'h000000});
        check_output("rd_valid_idle", 48'(bus.o_rd_valid), 48'd0);
        bus.i_frame_end = 1'b1;
        step();
        bus.i_frame_end = 1'b0;
        @(negedge clk);
        check_output("no_extra_toggle", 48'(bus.o_front_sel), 48'd0);

        // Swap requested during a clear of bank 1 waits; later commit coincides with a new clear.
        apply_stimulus_clear(20, 100, -1, 1'b0, 1'b0, 48'd0);
        step();
        step();
        @(negedge clk);
        check_output("pending_after_clear", 48'(bus.o_front_sel), 48'd0);
        apply_stimulus_clear(-1, -1, -1, 1'b1, 1'b1, 48'd0);
        apply_commit(1'b0);
        apply_read(11'd0, 24'h000000, 24'h000000);
        apply_read(11'd2047, 24'h000000, 24'h000000);

        // Reset in the middle of a clear with a read in flight and a swap pending.
        apply_write(12'd3, 24'hA5A5A5);
        apply_commit(1'b1);
        apply_read(11'd3, 24'hA5A5A5, 24'h000000);
        apply_stimulus_clear(20, -1, 100, 1'b0, 1'b1, {24'hA5A5A5, 24'h000000});
        step();
        step();
        rst = 1'b0;
        step();
        bus.i_frame_end = 1'b1;
        step();
        bus.i_frame_end = 1'b0;
        @(negedge clk);
        check_output("pending_cleared_by_rst", 48'(bus.o_front_sel), 48'd0);
        apply_stimulus_clear(-1, -1, -1, 1'b0, 1'b0, 48'd0);

        repeat (3) step();
        check_output("scoreboard_empty", 48'(exp_q.size()), 48'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
